lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter WORD_ADDR_W, 8, number of word-address bits decoded by the attached data memory (256 words).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_unsigned  input  1  loads: zero-extend instead of sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  access rejected, valid only with rsp_valid.
REQ-014 mem_read, mem_write  output  1 each  data-memory strobes.
REQ-015 mem_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  full write word; 0 when mem_write=0.
REQ-017 mem_rdata  input  32  combinational read data, valid the same cycle mem_read=1.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, MERGE_RD, MERGE_WR, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; the handshake req_valid&req_ready in cycle N SHALL latch all req_* fields.
REQ-020 Load or word store: IDLE->ACCESS (N+1)->RESP (N+2)->IDLE; rsp_valid=1 at N+2.
REQ-021 Byte/halfword store: IDLE->MERGE_RD (N+1, mem_read=1, word captured)->MERGE_WR (N+2, mem_write=1, merged word)->RESP (N+3)->IDLE.
REQ-022 Merge SHALL replace only the byte lanes selected by addr[1:0]/size; all other lanes SHALL keep the captured word.
REQ-023 Load extraction SHALL select the lane by addr[1:0] and sign-extend from bit 7/15 unless req_unsigned=1; word loads SHALL pass unchanged.
REQ-024 Error request (size=11, or any of addr[31:WORD_ADDR_W+2] set) SHALL go IDLE->ACCESS->RESP with no mem strobe, rsp_err=1, rsp_rdata=0.
REQ-025 mem_read and mem_write SHALL never be 1 in the same cycle; each SHALL pulse at most once per request.
REQ-026 rsp_valid SHALL not be back-pressured; outputs other than rsp_* SHALL be 0 in RESP and IDLE.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, req_ready=1 after release, and rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata to 0.
REQ-028 Reset during any non-IDLE state SHALL abandon the request with no response and no further mem_write.

Configuration
REQ-029 Macro LSU_MISALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL be treated as an error per REQ-024.
REQ-030 Macro undefined: misaligned low bits SHALL be ignored (halfword uses addr[1] only, word forced aligned), no misalignment error.

Structure
REQ-031 Package lsu_pkg SHALL hold the size encodings, the FSM state enum and WORD_ADDR_W default.
REQ-032 Combinational sub-module lsu_lane SHALL implement load extraction/extension and store merge; lsu_ctrl holds the FSM and registers.

Verification (memory word 0x10 preset to 0x804020F0)
REQ-033 LB addr 0x13, signed -> rsp_rdata 0xFFFFFF80 at N+2, rsp_err 0, single mem_read pulse.
REQ-034 LHU addr 0x12 -> rsp_rdata 0x00008040.
REQ-035 SB 0xAB to 0x11 -> mem_read N+1, mem_write N+2 with 0x8040ABF0, rsp at N+3.
REQ-036 SW 0x12345678 to 0x10 then LW 0x10 -> 0x12345678; LW 0x400 -> rsp_err 1, no strobes.
REQ-037 LW addr 0x12: with LSU_MISALIGN_CHECK_EN -> rsp_err 1, no strobes; without -> 0x804020F0.
REQ-038 SH 0xBEEF to 0x10, rst_n low in MERGE_RD -> no mem_write, word unchanged, no rsp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states,
// the latched request record and small lane-offset helpers.
package lsu_pkg;

   localparam int DEF_WORD_ADDR_W = 8;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_MERGE_RD,
      ST_MERGE_WR,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic        we;
      size_e       size;
      logic        is_unsigned;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
   } req_t;

   // Halfwords only honour addr[1] and words are always aligned, so stray low
   // address bits can never push a lane past the end of the word.
   function automatic logic [1:0] lane_offset(size_e size, logic [1:0] addr_lo);
      case (size)
         SIZE_BYTE: return addr_lo;
         SIZE_HALF: return {addr_lo[1], 1'b0};
         default:   return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
      return ((size == SIZE_HALF) && addr_lo[0]) ||
             ((size == SIZE_WORD) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: extracts and extends load data from a memory word, and
// merges sub-word store data into a previously read word.
module lsu_lane
   import lsu_pkg::*;
(
   input  size_e       size,
   input  logic        is_unsigned,
   input  logic [1:0]  offset,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_word
);

   logic [31:0] shifted;
   logic [31:0] lane_mask;

   // NOTE: every output of a combinational block gets a default before the
   // case statement; a path that leaves one unassigned would infer a latch.
   always_comb begin
      shifted   = rd_word >> {offset, 3'b000};
      load_data = rd_word;
      case (size)
         SIZE_BYTE: load_data = {{24{~is_unsigned & shifted[7]}},  shifted[7:0]};
         SIZE_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default:   load_data = rd_word;
      endcase
   end

   always_comb begin
      lane_mask = 32'hFFFF_FFFF;
      case (size)
         SIZE_BYTE: lane_mask = 32'h0000_00FF << {offset, 3'b000};
         SIZE_HALF: lane_mask = 32'h0000_FFFF << {offset, 3'b000};
         default:   lane_mask = 32'hFFFF_FFFF;
      endcase
      merge_word = (rd_word & ~lane_mask) | ((wdata << {offset, 3'b000}) & lane_mask);
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, sub-word stores done as
// read-modify-write. Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int WORD_ADDR_W = DEF_WORD_ADDR_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_e      state_q, state_d;
   req_t        req_q;
   logic [31:0] rdata_q;
   logic [31:0] word_q;
   logic        req_err;
   logic        sub_store;
   logic [31:0] word_addr;
   logic [31:0] lane_word;
   logic [31:0] load_data;
   logic [31:0] merge_word;

   always_comb begin
      req_err = (size_e'(req_size) == SIZE_RSVD) ||
                ((req_addr >> (WORD_ADDR_W + 2)) != 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
      req_err = req_err || is_misaligned(size_e'(req_size), req_addr[1:0]);
`endif
   end

   assign sub_store = req_we && !req_err &&
                      ((size_e'(req_size) == SIZE_BYTE) || (size_e'(req_size) == SIZE_HALF));
   assign word_addr = {req_q.addr[31:2], 2'b00};

   // Loads extract straight from the memory bus; merges use the captured word.
   assign lane_word = (state_q == ST_MERGE_WR) ? word_q : mem_rdata;

   lsu_lane u_lane (
      .size        (req_q.size),
      .is_unsigned (req_q.is_unsigned),
      .offset      (lane_offset(req_q.size, req_q.addr[1:0])),
      .rd_word     (lane_word),
      .wdata       (req_q.wdata),
      .load_data   (load_data),
      .merge_word  (merge_word)
   );

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = 32'd0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = sub_store ? ST_MERGE_RD : ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!req_q.err) begin
               mem_addr = word_addr;
               if (req_q.we) begin
                  mem_write = 1'b1;
                  mem_wdata = req_q.wdata;
               end else begin
                  mem_read = 1'b1;
               end
            end
            state_d = ST_RESP;
         end
         ST_MERGE_RD: begin
            mem_read = 1'b1;
            mem_addr = word_addr;
            state_d  = ST_MERGE_WR;
         end
         ST_MERGE_WR: begin
            mem_write = 1'b1;
            mem_addr  = word_addr;
            mem_wdata = merge_word;
            state_d   = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = req_q.err;
            rsp_rdata = rdata_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register in
   // this block samples the pre-edge values of the others.
   // NOTE: the datapath registers are reset too; they are only a few flops and
   // this keeps rsp_rdata and the lane inputs free of X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         rdata_q <= 32'd0;
         word_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && req_valid) begin
            req_q <= '{we:          req_we,
                       size:        size_e'(req_size),
                       is_unsigned: req_unsigned,
                       addr:        req_addr,
                       wdata:       req_wdata,
                       err:         req_err};
            rdata_q <= 32'd0;
         end
         if ((state_q == ST_ACCESS) && !req_q.we && !req_q.err) rdata_q <= load_data;
         if (state_q == ST_MERGE_RD) word_q <= mem_rdata;
      end
   end

endmodule
